// File: rtl/pc_pkg.sv
// pc_pkg: codes shared by programCounter and the fetch sequencer.
//  PS_*          : programCounter function select values
//  fetch_state_e : fetch sequencer state encoding
//  redirect_ps   : PS code for an absolute or PC-relative redirect
package pc_pkg;

    localparam logic [1:0] PS_HOLD   = 2'b00;  // PC <= PC
    localparam logic [1:0] PS_INC    = 2'b01;  // PC <= PC + 4
    localparam logic [1:0] PS_LOAD   = 2'b10;  // PC <= in
    localparam logic [1:0] PS_BRANCH = 2'b11;  // PC <= PC + 4 + in*4

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN,
        ST_FAULT
    } fetch_state_e;

    function automatic logic [1:0] redirect_ps(input logic rel);
        return rel ? PS_BRANCH : PS_LOAD;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory read bus, decode-side instruction
// handshake and the redirect request, bundled.
//  master : the fetch sequencer (drives imem_req/addr and instr*)
//  slave  : memory, decode and branch-resolution side
interface fetch_sequencer_if;

    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    logic        redirect_valid;
    logic        redirect_rel;
    logic [63:0] redirect_target;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready,
               redirect_valid, redirect_rel, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready,
               redirect_valid, redirect_rel, redirect_target
    );

endinterface

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: counts cycles a memory request has been outstanding.
//  clock, reset : rising edge, synchronous active-high reset
//  clear        : restart the count at zero
//  enable       : count this cycle
//  expired      : count has reached TIMEOUT (holds there)
module fetch_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    assign expired = (count_q == CW'(TIMEOUT));

    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = '0;
        else if (enable && !expired)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: boots programCounter to RESET_VECTOR, reads instruction
// memory at PC, hands each instruction to decode and steers PC (+4 or redirect).
// The block never adds: all PC arithmetic happens in programCounter via PS/pc_in.
//  clock, reset     : rising edge, synchronous active-high reset
//  PC               : current PC from programCounter
//  PS, pc_in        : programCounter function select / operand (combinational)
//  bus (master)     : imem req/ack read, instr valid/ready, redirect pulse
//  fetch_fault      : sticky; set on misaligned PC or memory timeout
//  fault_pc         : PC when the fault was taken
module fetch_sequencer
    import pc_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [63:0]       PC,
    output logic [1:0]        PS,
    output logic [63:0]       pc_in,
    fetch_sequencer_if.master bus,
    output logic              fetch_fault,
    output logic [63:0]       fault_pc
);

    fetch_state_e state_q, state_d;
    logic         imem_req_q, imem_req_d;
    logic [63:0]  imem_addr_q, imem_addr_d;
    logic [31:0]  instr_q, instr_d;
    logic [63:0]  instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic         fetch_fault_q, fetch_fault_d;
    logic [63:0]  fault_pc_q, fault_pc_d;
    logic         redir;
    logic         wd_expired;

    // The watchdog runs for as long as a request is on the bus (WAIT and DRAIN).
    fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (!imem_req_q),
        .enable  (imem_req_q),
        .expired (wd_expired)
    );

    // Redirects are meaningless before PC is booted and after a fault.
    assign redir = bus.redirect_valid && (state_q != ST_BOOT) && (state_q != ST_FAULT);

    always_comb begin
        state_d       = state_q;
        PS            = PS_HOLD;
        pc_in         = '0;
        imem_addr_d   = imem_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        fetch_fault_d = fetch_fault_q;
        fault_pc_d    = fault_pc_q;

        case (state_q)
            ST_BOOT: begin
                PS      = PS_LOAD;
                pc_in   = RESET_VECTOR;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // A redirect here reloads PC; fetch starts from the new PC next cycle.
                if (!redir) begin
                    if (PC[1:0] != 2'b00) begin
                        state_d       = ST_FAULT;
                        fetch_fault_d = 1'b1;
                        fault_pc_d    = PC;
                    end else begin
                        imem_addr_d = PC;
                        state_d     = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.imem_ack) begin
                    if (redir) begin
                        state_d = ST_FETCH;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        instr_pc_d = imem_addr_q;
                        state_d    = ST_HOLD;
                    end
                end else if (wd_expired) begin
                    state_d       = ST_FAULT;
                    fetch_fault_d = 1'b1;
                    fault_pc_d    = PC;
                end else if (redir) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (redir) begin
                    state_d = ST_FETCH;
                end else if (bus.instr_ready) begin
                    PS      = PS_INC;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // Stale read: wait it out, drop the data.
                if (bus.imem_ack) begin
                    state_d = ST_FETCH;
                end else if (wd_expired) begin
                    state_d       = ST_FAULT;
                    fetch_fault_d = 1'b1;
                    fault_pc_d    = PC;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Redirect overrides the +4 from a HOLD transfer in the same cycle.
        if (redir) begin
            PS    = redirect_ps(bus.redirect_rel);
            pc_in = bus.redirect_target;
        end

        if (reset) begin
            PS    = PS_HOLD;
            pc_in = '0;
        end

        imem_req_d    = (state_d == ST_WAIT) || (state_d == ST_DRAIN);
        instr_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = imem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign fetch_fault     = fetch_fault_q;
    assign fault_pc        = fault_pc_q;

endmodule
